// File: rtl/palette_mapper_if.sv
// Bundles the palette-write, pixel-index, fade-control and VGA colour signals of palette_mapper.
// The master side (the index generators / host) drives pixels, palette writes and fade requests.
interface palette_mapper_if #(
  parameter int IDX_W      = 4,
  parameter int NUM_LAYERS = 2
);
  logic                        pal_we;
  logic [IDX_W-1:0]            pal_waddr;
  logic [23:0]                 pal_wdata;
  logic                        pix_valid;
  logic [IDX_W-1:0]            bg_idx;
  logic [NUM_LAYERS-1:0]       layer_hit;
  logic [NUM_LAYERS*IDX_W-1:0] layer_idx;
  logic                        frame_tick;
  logic [2:0]                  fade_target;
  logic [7:0]                  VGA_R;
  logic [7:0]                  VGA_G;
  logic [7:0]                  VGA_B;
  logic                        out_valid;
  logic                        fade_busy;

  modport master (
    output pal_we, pal_waddr, pal_wdata, pix_valid, bg_idx, layer_hit, layer_idx,
           frame_tick, fade_target,
    input  VGA_R, VGA_G, VGA_B, out_valid, fade_busy
  );

  modport slave (
    input  pal_we, pal_waddr, pal_wdata, pix_valid, bg_idx, layer_hit, layer_idx,
           frame_tick, fade_target,
    output VGA_R, VGA_G, VGA_B, out_valid, fade_busy
  );
endinterface

// File: rtl/palette_mapper.sv
// Three-stage colour mapper: sprite/background select, writable palette lookup, then a
// frame-stepped brightness fade applied to every channel before the VGA outputs.
module palette_mapper #(
  parameter int IDX_W           = 4,
  parameter int NUM_LAYERS      = 2,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  palette_mapper_if.slave  bus
);

  localparam int               DEPTH  = 2**IDX_W;
  localparam logic [IDX_W-1:0] TRANSP = IDX_W'(TRANSPARENT_IDX);

  typedef enum logic {STEADY, STEPPING} fadeState_t;

  function automatic logic [23:0] palDefault(input int i);
    case (i)
      0:       return 24'hFF00FF;
      1:       return 24'h2D2D0C;
      2:       return 24'h282807;
      3:       return 24'h202000;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [7:0] fadeChan(input logic [7:0] c, input logic [3:0] s);
    return 8'(({4'b0, c} * {8'b0, s}) >> 3);
  endfunction

  logic [23:0]      r_pal [DEPTH];
  logic [IDX_W-1:0] r_s1Idx;
  logic             r_s1Valid;
  logic [23:0]      r_s2Rgb;
  logic             r_s2Valid;
  logic [7:0]       r_vgaR;
  logic [7:0]       r_vgaG;
  logic [7:0]       r_vgaB;
  logic             r_outValid;
  fadeState_t       r_fadeState;
  fadeState_t       w_nextState;
  logic [2:0]       r_fadeLevel;
  logic [2:0]       w_nextLevel;
  logic [2:0]       w_stepLevel;
  logic [IDX_W-1:0] w_winIdx;
  logic [3:0]       w_scale;

  // Walk from the lowest priority layer upward so the highest-priority opaque hit wins last.
  always_comb begin
    w_winIdx = bus.bg_idx;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (bus.layer_hit[k] && (bus.layer_idx[k*IDX_W +: IDX_W] != TRANSP)) begin
        w_winIdx = bus.layer_idx[k*IDX_W +: IDX_W];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pal[i] <= palDefault(i);
      end
    end else if (bus.pal_we) begin
      r_pal[bus.pal_waddr] <= bus.pal_wdata;
    end
  end

  // The lookup samples the array before this edge's write lands, giving old-data on collision.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1Idx   <= '0;
      r_s1Valid <= 1'b0;
      r_s2Rgb   <= '0;
      r_s2Valid <= 1'b0;
    end else begin
      r_s1Idx   <= w_winIdx;
      r_s1Valid <= bus.pix_valid;
      r_s2Rgb   <= r_pal[r_s1Idx];
      r_s2Valid <= r_s1Valid;
    end
  end

  assign w_scale = 4'd8 - {1'b0, r_fadeLevel};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vgaR     <= '0;
      r_vgaG     <= '0;
      r_vgaB     <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= r_s2Valid;
      r_vgaR     <= r_s2Valid ? fadeChan(r_s2Rgb[23:16], w_scale) : 8'h00;
      r_vgaG     <= r_s2Valid ? fadeChan(r_s2Rgb[15:8],  w_scale) : 8'h00;
      r_vgaB     <= r_s2Valid ? fadeChan(r_s2Rgb[7:0],   w_scale) : 8'h00;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fadeState <= STEADY;
      r_fadeLevel <= '0;
    end else begin
      r_fadeState <= w_nextState;
      r_fadeLevel <= w_nextLevel;
    end
  end

  // A target change is seen directly, so a tick always steps toward the latest request.
  always_comb begin
    w_nextState = r_fadeState;
    w_nextLevel = r_fadeLevel;
    w_stepLevel = r_fadeLevel;
    if (r_fadeLevel < bus.fade_target) begin
      w_stepLevel = r_fadeLevel + 3'd1;
    end else if (r_fadeLevel > bus.fade_target) begin
      w_stepLevel = r_fadeLevel - 3'd1;
    end
    case (r_fadeState)
      STEADY: begin
        if (r_fadeLevel != bus.fade_target) begin
          w_nextState = STEPPING;
          if (bus.frame_tick) begin
            w_nextLevel = w_stepLevel;
          end
        end
      end
      STEPPING: begin
        if (bus.frame_tick) begin
          w_nextLevel = w_stepLevel;
        end
        w_nextState = (w_nextLevel == bus.fade_target) ? STEADY : STEPPING;
      end
      default: w_nextState = STEADY;
    endcase
  end

  assign bus.VGA_R     = r_vgaR;
  assign bus.VGA_G     = r_vgaG;
  assign bus.VGA_B     = r_vgaB;
  assign bus.out_valid = r_outValid;
  assign bus.fade_busy = !Reset && (r_fadeLevel != bus.fade_target);

endmodule

// File: doc/palette_mapper.md
# palette_mapper

Pipelined, parameterised colour mapper for the VGA datapath. It replaces the fixed four-entry colour lookup with a writable palette and N prioritised sprite layers with a transparency key. It also adds a frame-stepped fade engine for screen transitions. It sits between the sprite/background index generators and the VGA RGB outputs, with a fixed 3-cycle latency from pixel index to colour.

## Interface
Parameters:
- IDX_W, 4: palette index width; palette depth = 2**IDX_W entries of 24 bits.
- NUM_LAYERS, 2: number of sprite layers above the background; layer 0 has highest priority.
- TRANSPARENT_IDX, 0: sprite index value treated as see-through.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- pal_we  in  1  palette write enable.
- pal_waddr  in  IDX_W  palette write address.
- pal_wdata  in  24  {R,G,B} written to pal_waddr.
- pix_valid  in  1  pixel inside the active area.
- bg_idx  in  IDX_W  background palette index.
- layer_hit  in  NUM_LAYERS  bit k set means layer k covers the current pixel.
- layer_idx  in  NUM_LAYERS*IDX_W  layer k index in bits [k*IDX_W +: IDX_W].
- frame_tick  in  1  one-cycle pulse per frame.
- fade_target  in  3  requested fade level: 0 = full brightness, 7 = black.
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour.
- out_valid  out  1  pix_valid delayed by 3 cycles.
- fade_busy  out  1  asserted while fade_level != fade_target.

## Operation
- **Reset palette.** Entry 0 = FF00FF, 1 = 2D2D0C, 2 = 282807, 3 = 202000, all others = 000000. Reset restores these values even if the palette has been written.
- **Stage 1 (select).**
  - Winner is the lowest k with layer_hit[k] = 1 and layer_idx[k] != TRANSPARENT_IDX.
  - If no layer qualifies, the winner is bg_idx. bg_idx is never treated as transparent.
  - Register the winning index and pix_valid.
- **Stage 2 (lookup).** Registered palette read of the stage-1 index. Carry the valid bit.
- **Stage 3 (fade).**
  - Each channel c is output as (c * (8 - fade_level)) >> 3, using 8x4-bit multiply and truncation.
  - If the stage-2 valid bit is 0, output 000000 and out_valid = 0.
- **Palette write.** On a clock edge with pal_we = 1, entry pal_waddr takes pal_wdata.
  - A stage-2 read of the same address in the same cycle returns the old value.
  - Reads in the next cycle and later return the new value.
  - Writes are accepted whether or not pixels are valid.
- **Fade engine.** fade_level is 3 bits with states STEADY and STEPPING.
  - STEADY: fade_level == fade_target; fade_busy = 0.
  - STEPPING: on each frame_tick, fade_level moves one step toward fade_target (+1 or -1); fade_busy = 1.
  - If fade_target changes mid-fade, the next tick steps toward the new target. No wrap: level saturates at the target.
  - fade_level and fade_target equal on a frame_tick cycle: no change.
  - fade_level is registered on frame_tick and applies to every pixel in stage 3 from the next cycle.

## Timing
- **Latency.** Inputs sampled at edge n appear on VGA_R/G/B and out_valid after edge n+3. Throughput is one pixel per clock with no stalls.
- **Reset values (held while Reset = 1).**
  - VGA_R/G/B = 00, out_valid = 0.
  - Pipeline valid bits = 0, fade_level = 0, fade_busy = 0.
  - Palette = defaults.
- **Leaving reset.** The first valid output appears 3 cycles after the first pix_valid sampled once Reset is low.
- **Reset mid-frame.** In-flight pixels are discarded. Pixel writes pending in the same cycle as Reset are ignored.
- **fade_busy** is combinational from the registered fade_level and the sampled fade_target.

## Test plan
- **Reset defaults.** Reset, then bg_idx = 1, pix_valid = 1, no layer hits -> out RGB 2D,2D,0C at cycle 3 with out_valid = 1. bg_idx = 5 -> 00,00,00.
- **Priority and transparency.** NUM_LAYERS = 2, layer_hit = 11, layer_idx[0] = 0 (transparent), layer_idx[1] = 3 -> colour 20,20,00. Then layer_idx[0] = 2 -> 28,28,07.
- **Write collision.** Write entry 2 = 123456 in cycle n while stage 2 reads entry 2 in cycle n -> old 282807. A read in cycle n+1 -> 123456.
- **Fade ramp.** fade_target = 4 from level 0. After 4 frame_ticks, entry 0 outputs 7F,00,7F and fade_busy falls. fade_target = 0 -> 4 ticks back to FF,00,FF.
- **Blanking.** pix_valid = 0 for one pixel in a stream -> that output slot is 000000 with out_valid = 0. Neighbours are unaffected.
- **Mid-stream reset.** Assert Reset for one cycle during a pixel stream after palette writes -> outputs 0 for 3 cycles after release, and default palette values return.
